// File: rtl/wb_arb_pkg.sv
// Shared types and defaults for the two-master Wishbone SDRAM arbiter.
package wb_arb_pkg;

   typedef enum logic [1:0] {IDLE, GNT0, GNT1, DRAIN} arb_state_t;

   localparam int unsigned STARVE_MAX_DEF = 64;
   localparam int unsigned TIMEOUT_DEF    = 1024;

   function automatic logic [1:0] onehot_gnt(input arb_state_t st);
      case (st)
         GNT0:    onehot_gnt = 2'b01;
         GNT1:    onehot_gnt = 2'b10;
         default: onehot_gnt = 2'b00;
      endcase
   endfunction

endpackage

// File: rtl/wb_arb_watchdog.sv
// Bus-hang watchdog: counts strobed cycles without ack and fires a one-cycle
// pulse when a granted cycle has waited TIMEOUT strobes.
module wb_arb_watchdog
   import wb_arb_pkg::*;
#(
   parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_clr,
   input  logic i_stb,
   input  logic i_ack,
   output logic o_fire
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT) + 1;

   logic [CNT_W-1:0] r_wd_cnt;
   logic             w_at_limit;

   assign w_at_limit = (r_wd_cnt == CNT_W'(TIMEOUT - 1));
   assign o_fire     = i_stb & ~i_ack & w_at_limit;

   // Holds at the limit so the pulse cannot repeat before the next grant clears it.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_wd_cnt <= '0;
      end else if (i_clr || i_ack) begin
         r_wd_cnt <= '0;
      end else if (i_stb && !w_at_limit) begin
         r_wd_cnt <= r_wd_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/wb_sdram_arbiter.sv
// Two-master Wishbone arbiter for the SDRAM slave: DMA (m0) has fixed priority,
// the CPU (m1) gets a bounded starvation limit, and a watchdog breaks bus hangs.
module wb_sdram_arbiter
   import wb_arb_pkg::*;
#(
   parameter int unsigned  ADDR_W     = 32,
   parameter int unsigned  DATA_W     = 32,
   parameter int unsigned  STARVE_MAX = STARVE_MAX_DEF,
   parameter int unsigned  TIMEOUT    = TIMEOUT_DEF,
   localparam int unsigned SEL_W      = DATA_W / 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              m0_cyc,
   input  logic              m0_stb,
   input  logic              m0_we,
   input  logic [ADDR_W-1:0] m0_adr,
   input  logic [DATA_W-1:0] m0_dat_w,
   input  logic [SEL_W-1:0]  m0_sel,
   output logic [DATA_W-1:0] m0_dat_r,
   output logic              m0_ack,
   output logic              m0_err,
   input  logic              m1_cyc,
   input  logic              m1_stb,
   input  logic              m1_we,
   input  logic [ADDR_W-1:0] m1_adr,
   input  logic [DATA_W-1:0] m1_dat_w,
   input  logic [SEL_W-1:0]  m1_sel,
   output logic [DATA_W-1:0] m1_dat_r,
   output logic              m1_ack,
   output logic              m1_err,
   output logic              s_cyc,
   output logic              s_stb,
   output logic              s_we,
   output logic [ADDR_W-1:0] s_adr,
   output logic [DATA_W-1:0] s_dat_w,
   output logic [SEL_W-1:0]  s_sel,
   input  logic [DATA_W-1:0] s_dat_r,
   input  logic              s_ack,
   output logic [1:0]        gnt,
   output logic              timeout_evt
);

   localparam int unsigned SC_W = $clog2(STARVE_MAX + 1);

   arb_state_t      r_state, w_state_nxt;
   logic            r_owner;  // remembers the owner through DRAIN, where gnt reads 00
   logic [SC_W-1:0] r_starve_cnt;
   logic            w_own0, w_own1, w_owner_cyc, w_starved, w_grant_entry, w_fire;

   assign w_own0        = (r_state == GNT0);
   assign w_own1        = (r_state == GNT1);
   assign w_owner_cyc   = r_owner ? m1_cyc : m0_cyc;
   assign w_starved     = (r_starve_cnt >= SC_W'(STARVE_MAX));
   assign w_grant_entry = (r_state == IDLE) && (w_state_nxt != IDLE);

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         IDLE: begin
            if (w_starved && m1_cyc) w_state_nxt = GNT1;
            else if (m0_cyc)         w_state_nxt = GNT0;
            else if (m1_cyc)         w_state_nxt = GNT1;
         end
         GNT0, GNT1: begin
            if (w_fire)            w_state_nxt = DRAIN;
            else if (!w_owner_cyc) w_state_nxt = IDLE;
         end
         DRAIN: begin
            if (!w_owner_cyc) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_owner <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_state_nxt == GNT0)      r_owner <= 1'b0;
         else if (w_state_nxt == GNT1) r_owner <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_starve_cnt <= '0;
      end else if (!m1_cyc || (w_state_nxt == GNT1 && r_state != GNT1)) begin
         r_starve_cnt <= '0;
      end else if (r_state != GNT1 && !w_starved) begin
         r_starve_cnt <= r_starve_cnt + 1'b1;
      end
   end

   always_comb begin
      s_cyc   = 1'b0;
      s_stb   = 1'b0;
      s_we    = 1'b0;
      s_adr   = '0;
      s_dat_w = '0;
      s_sel   = '0;
      if (w_own0) begin
         s_cyc   = m0_cyc;
         s_stb   = m0_cyc & m0_stb;
         s_we    = m0_we;
         s_adr   = m0_adr;
         s_dat_w = m0_dat_w;
         s_sel   = m0_sel;
      end else if (w_own1) begin
         s_cyc   = m1_cyc;
         s_stb   = m1_cyc & m1_stb;
         s_we    = m1_we;
         s_adr   = m1_adr;
         s_dat_w = m1_dat_w;
         s_sel   = m1_sel;
      end
   end

   assign m0_ack      = w_own0 & s_ack;
   assign m1_ack      = w_own1 & s_ack;
   assign m0_err      = w_own0 & w_fire;
   assign m1_err      = w_own1 & w_fire;
   assign m0_dat_r    = s_dat_r;
   assign m1_dat_r    = s_dat_r;
   assign gnt         = onehot_gnt(r_state);
   assign timeout_evt = w_fire;

   wb_arb_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_clr   (w_grant_entry),
      .i_stb   (s_stb),
      .i_ack   (s_ack),
      .o_fire  (w_fire)
   );

endmodule

// File: tb/tb_wb_sdram_arbiter.sv
// Self-checking bench for wb_sdram_arbiter: directed arbitration scenarios plus
// randomized two-master traffic checked by a per-master expected-transaction scoreboard.
module tb_wb_sdram_arbiter;

   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned SW = 4;

   typedef struct packed {
      logic          we;
      logic [AW-1:0] adr;
      logic [DW-1:0] dat;
      logic [SW-1:0] sel;
   } txn_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [1:0]    m_cyc, m_stb, m_we, m_ack, m_err;
   logic [AW-1:0] m_adr   [2];
   logic [DW-1:0] m_dat_w [2];
   logic [DW-1:0] m_dat_r [2];
   logic [SW-1:0] m_sel   [2];
   logic          s_cyc, s_stb, s_we, s_ack;
   logic [AW-1:0] s_adr;
   logic [DW-1:0] s_dat_w, s_dat_r;
   logic [SW-1:0] s_sel;
   logic [1:0]    gnt;
   logic          timeout_evt;

   int   checks = 0;
   int   errors = 0;
   txn_t q0[$];
   txn_t q1[$];

   always #5 clk = ~clk;

   wb_sdram_arbiter #(
      .ADDR_W     (AW),
      .DATA_W     (DW),
      .STARVE_MAX (64),
      .TIMEOUT    (16)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .m0_cyc      (m_cyc[0]),
      .m0_stb      (m_stb[0]),
      .m0_we       (m_we[0]),
      .m0_adr      (m_adr[0]),
      .m0_dat_w    (m_dat_w[0]),
      .m0_sel      (m_sel[0]),
      .m0_dat_r    (m_dat_r[0]),
      .m0_ack      (m_ack[0]),
      .m0_err      (m_err[0]),
      .m1_cyc      (m_cyc[1]),
      .m1_stb      (m_stb[1]),
      .m1_we       (m_we[1]),
      .m1_adr      (m_adr[1]),
      .m1_dat_w    (m_dat_w[1]),
      .m1_sel      (m_sel[1]),
      .m1_dat_r    (m_dat_r[1]),
      .m1_ack      (m_ack[1]),
      .m1_err      (m_err[1]),
      .s_cyc       (s_cyc),
      .s_stb       (s_stb),
      .s_we        (s_we),
      .s_adr       (s_adr),
      .s_dat_w     (s_dat_w),
      .s_sel       (s_sel),
      .s_dat_r     (s_dat_r),
      .s_ack       (s_ack),
      .gnt         (gnt),
      .timeout_evt (timeout_evt)
   );

   // Slave model: acks a strobed cycle after sl_lat extra cycles; read data is a
   // fixed function of the address so expected read data is known up front.
   int   sl_lat   = 0;
   bit   sl_noack = 1'b0;
   int   sl_cnt   = 0;
   logic sl_ack_q = 1'b0;

   assign s_ack   = sl_ack_q;
   assign s_dat_r = s_adr ^ 32'hDEADBEEF;

   always @(posedge clk) begin
      if (s_cyc && s_stb && !sl_ack_q && !sl_noack) begin
         if (sl_cnt >= sl_lat) begin
            sl_ack_q <= 1'b1;
            sl_cnt   <= 0;
         end else begin
            sl_cnt <= sl_cnt + 1;
         end
      end else begin
         sl_ack_q <= 1'b0;
         if (!(s_cyc && s_stb)) sl_cnt <= 0;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual %0h required %0h", name, act, exp);
      end
   endtask

   task automatic check_ack(input int m);
      txn_t e;
      int   depth;
      depth = (m == 0) ? q0.size() : q1.size();
      if (depth == 0) begin
         checks++;
         errors++;
         $display("FAIL ack_unexpected_m%0d: actual ack=1 required no ack", m);
         return;
      end
      if (m == 0) e = q0.pop_front();
      else        e = q1.pop_front();
      chk($sformatf("m%0d_s_adr", m), s_adr, e.adr);
      chk($sformatf("m%0d_s_we", m), {31'b0, s_we}, {31'b0, e.we});
      chk($sformatf("m%0d_s_sel", m), {28'b0, s_sel}, {28'b0, e.sel});
      if (e.we) chk($sformatf("m%0d_s_dat_w", m), s_dat_w, e.dat);
      else      chk($sformatf("m%0d_dat_r", m), m_dat_r[m], e.adr ^ 32'hDEADBEEF);
   endtask

   // Monitor: pops the scoreboard on every master ack and checks routing invariants.
   always @(negedge clk) begin
      for (int m = 0; m < 2; m++) begin
         if (m_ack[m]) check_ack(m);
      end
      chk("gnt_not_both", {31'b0, gnt == 2'b11}, 32'd0);
      if (gnt != 2'b01) chk("m0_nonowner_term", {30'b0, m_ack[0], m_err[0]}, 32'd0);
      if (gnt != 2'b10) chk("m1_nonowner_term", {30'b0, m_ack[1], m_err[1]}, 32'd0);
      if (gnt == 2'b00) chk("idle_s_cyc", {31'b0, s_cyc}, 32'd0);
   end

   task automatic drive(input int m, input logic cyc, input logic stb, input logic we,
                        input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                        input logic [SW-1:0] sel);
      m_cyc[m]   = cyc;
      m_stb[m]   = stb;
      m_we[m]    = we;
      m_adr[m]   = adr;
      m_dat_w[m] = dat;
      m_sel[m]   = sel;
   endtask

   task automatic issue(input int m, input logic we, input logic [AW-1:0] adr);
      txn_t t;
      t.we  = we;
      t.adr = adr;
      t.dat = $urandom;
      t.sel = 4'($urandom_range(15));
      drive(m, 1'b1, 1'b1, we, t.adr, t.dat, t.sel);
      if (m == 0) q0.push_back(t);
      else        q1.push_back(t);
   endtask

   task automatic wait_ack(input int m, input int budget, output bit got);
      got = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (m_ack[m]) begin
            got = 1'b1;
            break;
         end
      end
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL ack_timeout_m%0d: actual no ack in %0d cycles required ack", m, budget);
         if (m == 0 && q0.size() > 0) void'(q0.pop_back());
         if (m == 1 && q1.size() > 0) void'(q1.pop_back());
      end
   endtask

   task automatic wb_txn(input int m, input logic we, input logic [AW-1:0] base,
                         input int nbeats);
      bit got;
      for (int b = 0; b < nbeats; b++) begin
         issue(m, we, base + 32'(4 * b));
         wait_ack(m, 200, got);
         @(posedge clk); #1;
         if (!got) break;
      end
      drive(m, 1'b0, 1'b0, 1'b0, '0, '0, '0);
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   logic [1:0] hist [14];
   int         first_nz, last01, first10, n_stb, n_cyc, err_at, n_err, n_evt, n_ack, mode, gap;
   bit         got;

   initial begin
      rst_n = 1'b0;
      drive(0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
      drive(1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_gnt", {30'b0, gnt}, 32'd0);
      chk("rst_s_cyc_stb", {30'b0, s_cyc, s_stb}, 32'd0);
      chk("rst_s_adr", s_adr, 32'd0);
      chk("rst_term", {28'b0, m_ack, m_err}, 32'd0);
      chk("rst_evt", {31'b0, timeout_evt}, 32'd0);
      step();
      rst_n = 1'b1;

      // Single m1 read: one cycle of grant latency, then data DEADBEEF from address 0.
      step();
      sl_lat = 2;
      txn_t_issue_m1: begin
         txn_t t;
         t = '{we: 1'b0, adr: 32'h0, dat: 32'h0, sel: 4'hF};
         drive(1, 1'b1, 1'b1, 1'b0, t.adr, t.dat, t.sel);
         q1.push_back(t);
      end
      @(negedge clk);
      chk("t1_s_cyc_req_cycle", {31'b0, s_cyc}, 32'd0);
      chk("t1_gnt_req_cycle", {30'b0, gnt}, 32'd0);
      @(negedge clk);
      chk("t1_s_cyc_granted", {31'b0, s_cyc}, 32'd1);
      chk("t1_gnt_granted", {30'b0, gnt}, 32'd2);
      wait_ack(1, 20, got);
      chk("t1_dat_r", m_dat_r[1], 32'hDEADBEEF);
      step();
      drive(1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
      @(negedge clk);
      chk("t1_ack_width", {31'b0, m_ack[1]}, 32'd0);
      @(negedge clk);
      chk("t1_gnt_released", {30'b0, gnt}, 32'd0);

      // Simultaneous requests: m0 first, exactly one idle cycle, then m1.
      step();
      sl_lat = 0;
      fork
         wb_txn(0, 1'b0, 32'h100, 1);
         wb_txn(1, 1'b0, 32'h200, 1);
         for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            hist[i] = gnt;
         end
      join
      first_nz = 0;
      last01   = -1;
      first10  = -1;
      for (int i = 13; i >= 0; i--) if (hist[i] != 2'b00) first_nz = int'(hist[i]);
      for (int i = 0; i < 14; i++) begin
         if (hist[i] == 2'b01) last01 = i;
         if (hist[i] == 2'b10 && first10 < 0) first10 = i;
      end
      chk("t2_first_owner", 32'(first_nz), 32'd1);
      chk("t2_idle_gap", 32'(first10 - last01), 32'd2);

      // Starvation: m0 locks the bus 200 cycles; m1 must win the next arbitration.
      step();
      drive(0, 1'b1, 1'b0, 1'b0, '0, '0, '0);
      step();
      issue(1, 1'b0, 32'h300);
      repeat (199) @(posedge clk);
      @(negedge clk);
      chk("t3_starve_sat", 32'(dut.r_starve_cnt), 32'd64);
      chk("t3_m0_holds", {30'b0, gnt}, 32'd1);
      step();
      drive(0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
      step();
      issue(0, 1'b0, 32'h400);
      @(negedge clk);
      chk("t3_idle_cycle", {30'b0, gnt}, 32'd0);
      @(negedge clk);
      chk("t3_m1_forced", {30'b0, gnt}, 32'd2);
      wait_ack(1, 20, got);
      step();
      drive(1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
      wait_ack(0, 20, got);
      step();
      drive(0, 1'b0, 1'b0, 1'b0, '0, '0, '0);

      // Watchdog: slave never acks an m1 write.
      step();
      sl_noack = 1'b1;
      drive(1, 1'b1, 1'b1, 1'b1, 32'h500, 32'h12345678, 4'hF);
      n_stb  = 0;
      n_cyc  = 0;
      err_at = -1;
      n_err  = 0;
      n_evt  = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (s_stb) n_stb++;
         if (s_cyc) n_cyc++;
         if (m_err[1]) begin
            n_err++;
            if (err_at < 0) err_at = n_stb;
         end
         if (timeout_evt) n_evt++;
      end
      chk("t4_err_stb_cycle", 32'(err_at), 32'd16);
      chk("t4_err_count", 32'(n_err), 32'd1);
      chk("t4_evt_count", 32'(n_evt), 32'd1);
      chk("t4_stb_total", 32'(n_stb), 32'd16);
      chk("t4_cyc_total", 32'(n_cyc), 32'd16);
      step();
      issue(0, 1'b0, 32'h540);
      n_cyc = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (s_cyc || gnt != 2'b00) n_cyc++;
      end
      chk("t4_drain_blocks_m0", 32'(n_cyc), 32'd0);
      step();
      sl_noack = 1'b0;
      drive(1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
      wait_ack(0, 30, got);
      step();
      drive(0, 1'b0, 1'b0, 1'b0, '0, '0, '0);

      // Reset after beat 2 of a 4-beat m0 burst.
      step();
      sl_lat = 1;
      for (int b = 0; b < 2; b++) begin
         issue(0, 1'b0, 32'h600 + 32'(4 * b));
         wait_ack(0, 20, got);
         step();
      end
      drive(0, 1'b1, 1'b1, 1'b0, 32'h608, '0, 4'hF);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      @(negedge clk);
      chk("t5_s_cyc_after_rst", {31'b0, s_cyc}, 32'd0);
      chk("t5_gnt_after_rst", {30'b0, gnt}, 32'd0);
      step();
      drive(0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
      n_ack = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (m_ack[0]) n_ack++;
      end
      chk("t5_no_more_ack", 32'(n_ack), 32'd0);

      // m0 drops cyc in its ack cycle while m1 waits.
      step();
      sl_lat = 1;
      issue(0, 1'b0, 32'h700);
      issue(1, 1'b0, 32'h800);
      wait_ack(0, 20, got);
      m_cyc[0] = 1'b0;
      m_stb[0] = 1'b0;
      #1;
      chk("t6_ack_with_drop", {31'b0, m_ack[0]}, 32'd1);
      @(negedge clk);
      chk("t6_idle_after_drop", {30'b0, gnt}, 32'd0);
      @(negedge clk);
      chk("t6_m1_next", {30'b0, gnt}, 32'd2);
      wait_ack(1, 20, got);
      step();
      drive(1, 1'b0, 1'b0, 1'b0, '0, '0, '0);

      // Randomized traffic from one or both masters.
      for (int it = 0; it < 40; it++) begin
         step();
         sl_lat = $urandom_range(0, 3);
         mode   = $urandom_range(0, 2);
         fork
            if (mode != 1) wb_txn(0, 1'($urandom_range(1)), $urandom & 32'hFFFF_FFFC,
                                  $urandom_range(1, 4));
            if (mode != 0) wb_txn(1, 1'($urandom_range(1)), $urandom & 32'hFFFF_FFFC,
                                  $urandom_range(1, 4));
         join
         gap = $urandom_range(0, 2);
         repeat (gap) step();
      end

      repeat (4) step();
      chk("q0_drained", 32'(q0.size()), 32'd0);
      chk("q1_drained", 32'(q1.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: actual still running required finish");
      $fatal(1);
   end

endmodule

// File: doc/wb_sdram_arbiter.md
Name: wb_sdram_arbiter

Overview:
- Two-master Wishbone B3 arbiter that shares the single wb_sdram16 slave port between the LCD screen DMA (master 0, real-time) and the ThermoProcessor (master 1).
- Sits between the lcd_bus/sdr_bus masters and the SDRAM controller, on the 25 MHz system clock.
- Fixed priority to the DMA, with a bounded starvation limit for the CPU and a per-cycle bus-hang watchdog.

Parameters:
- ADDR_W, 32, Wishbone address width.
- DATA_W, 32, Wishbone data width; SEL_W = DATA_W/8.
- STARVE_MAX, 64, cycles master 1 may wait while master 0 holds or re-wins before master 1 is forced next.
- TIMEOUT, 1024, cycles a granted cycle may go without ack before the watchdog fires.

Ports:
- clk  in  1  system clock (25 MHz)
- rst_n  in  1  synchronous, active-low reset
- m0_cyc, m0_stb, m0_we  in  1 each  DMA Wishbone control
- m0_adr  in  ADDR_W  DMA address
- m0_dat_w  in  DATA_W  DMA write data
- m0_sel  in  SEL_W  DMA byte selects
- m0_dat_r  out  DATA_W  read data to DMA
- m0_ack, m0_err  out  1 each  DMA termination
- m1_*  same set as m0_*  CPU master
- s_cyc, s_stb, s_we  out  1 each  to SDRAM controller
- s_adr  out  ADDR_W
- s_dat_w  out  DATA_W
- s_sel  out  SEL_W
- s_dat_r  in  DATA_W
- s_ack  in  1
- gnt  out  2  one-hot current owner, for debug LEDs
- timeout_evt  out  1  one-cycle pulse when the watchdog fires

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE, gnt=00, starve_cnt=0, wd_cnt=0, timeout_evt=0. All s_* and m*_ack/err outputs are 0 while gnt=00.
- FSM states:
  - IDLE:
    - if starve_cnt>=STARVE_MAX and m1_cyc -> GNT1;
    - else if m0_cyc -> GNT0;
    - else if m1_cyc -> GNT1.
    - Grant is registered, so there is 1 cycle of latency from cyc to s_cyc.
  - GNT0 / GNT1:
    - Owner's signals drive s_* combinationally; s_cyc = owner_cyc & ~wd_kill.
    - Stays while owner cyc=1 (bursts and locked sequences are not split).
    - Owner cyc=0 -> IDLE; gnt=00 in the IDLE cycle, giving one dead cycle between owners.
    - Watchdog fired -> DRAIN.
  - DRAIN: s_cyc=s_stb=0; hold until owner drops cyc, then IDLE.
- Data and termination routing:
  - s_ack routed only to owner's m*_ack; non-owner ack=err=0.
  - m0_dat_r = m1_dat_r = s_dat_r unconditionally (qualified by ack).
- starve_cnt:
  - Increments (saturating at STARVE_MAX) each cycle m1_cyc=1 and gnt!=GNT1.
  - Clears when GNT1 is entered or m1_cyc=0.
- wd_cnt:
  - Clears on grant entry and on every s_ack; otherwise increments while s_stb=1.
  - At wd_cnt==TIMEOUT-1 with no ack: owner's m*_err=1 for exactly one cycle, timeout_evt=1 for one cycle, then -> DRAIN.
- Simultaneous requests in IDLE: m0 wins unless the starve condition holds.
- Owner drops cyc in the same cycle as s_ack: ack is still delivered, then -> IDLE.
- Reset asserted mid-transfer: return to IDLE next edge, drop s_cyc immediately (registered gnt=00). The slave must tolerate an aborted cycle.
- Non-owner stb/we/adr are ignored; no buffering.

Decomposition:
- Package wb_arb_pkg:
  - typedef enum logic [1:0] {IDLE, GNT0, GNT1, DRAIN} arb_state_t
  - localparams for default STARVE_MAX and TIMEOUT
  - function onehot_gnt(arb_state_t)
- One sub-module is natural: wb_arb_watchdog (wd_cnt, err pulse, timeout_evt), reusable on lcd_bus.
- The s_* mux stays inline.

Test Plan:
- Reset, then m1_cyc=1 single read with slave ack after 3 cycles -> s_cyc rises 1 cycle after m1_cyc; m1_ack is 1 cycle wide; m1_dat_r=0xDEADBEEF; gnt=10 then 00.
- m0_cyc and m1_cyc rise on the same cycle -> gnt=01 first; after m0 drops cyc, one IDLE cycle, then gnt=10.
- m0 holds a continuous burst for 200 cycles with STARVE_MAX=64 while m1 waits -> m1 is granted immediately after m0's cycle ends even though m0 re-requests in IDLE; starve_cnt saturates at 64.
- Slave never acks an m1 write, TIMEOUT=16 -> m1_err=1 exactly on cycle 16 of stb; timeout_evt pulses once; s_cyc=0 afterwards until m1 drops cyc; m0 is then served normally.
- rst_n=0 for 1 cycle mid-way through an m0 4-beat burst (after beat 2) -> s_cyc=0 next cycle, gnt=00, no further m0_ack.
- m0 drops cyc on the same cycle as its final s_ack while m1 is waiting -> m0_ack=1 that cycle; IDLE next cycle; gnt=10 the cycle after.
